multicycle_controller: RTL
==========================

# multicycle_controller

Moore-style finite-state controller that sequences a shared multicycle RV32I datapath. A single memory port serves both fetch and data, and one ALU is reused across cycles. It replaces the combinational single-cycle controller. From the decoded opcode fields and the datapath `Zero` flag, it drives every datapath enable and mux select, stalls on a memory ready handshake, and halts in a trap state on unsupported opcodes.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 7: opcode field of the instruction register.
- `funct3` in 3: funct3 field.
- `funct7b5` in 1: bit 30 of the instruction.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: result select, 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select, 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: ALU B select, 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUControl` out 3: ALU operation, 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: immediate format, 00 I, 01 S, 10 B, 11 J.
- `Retire` out 1: one-cycle pulse when an instruction completes.
- `Illegal` out 1: high while in TRAP.
- `State` out 4: current state encoding, for debug.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
- Codes 12–15 are unreachable and must transition to FETCH.
- Transitions:
  - FETCH goes to DECODE when `MemReady`=1, else stays in FETCH.
  - DECODE goes to MEMADR for op 0000011 or 0100011.
  - DECODE goes to EXECUTER for op 0110011.
  - DECODE goes to EXECUTEI for op 0010011.
  - DECODE goes to BEQ for op 1100011.
  - DECODE goes to JAL for op 1101111.
  - DECODE goes to TRAP for any other op.
  - MEMADR goes to MEMREAD if op[5]=0, else to MEMWRITE.
  - MEMREAD goes to MEMWB when `MemReady`=1, else stays.
  - MEMWRITE goes to FETCH when `MemReady`=1, else stays.
  - EXECUTER and EXECUTEI go to ALUWB.
  - JAL goes to ALUWB.
  - MEMWB, ALUWB and BEQ go to FETCH.
  - TRAP stays in TRAP until reset.
- Per-state outputs (all unlisted outputs are 0):
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10. IRWrite and PC update equal `MemReady`.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp add (computes the branch target).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp add.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1. MemWrite is held until `MemReady`.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp funct.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp funct.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, Branch 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp add, ResultSrc 00, PC update 1.
  - TRAP: Illegal 1.
- PCWrite = PC update | (Branch & `Zero`).
- ALU decode for ALUOp funct:
  - funct3 000: sub when op[5]=1 and funct7b5=1, otherwise add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3: add.
- ImmSrc is combinational from `op`:
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 1101111 gives 11.
  - Any other op gives 00.
- `Retire` pulses in the cycle in which the FSM leaves MEMWB, ALUWB, BEQ, or MEMWRITE with `MemReady`=1.

## Timing
- State is registered on the rising edge of `clk`. Outputs are combinational from state (plus `MemReady`, `Zero`, `op`, `funct3` and `funct7b5` where noted).
- `reset`=0 asynchronously forces the FETCH state.
- While `reset`=0, PCWrite, IRWrite, RegWrite, MemWrite and `Retire` are forced to 0.
- A reset asserted mid-instruction aborts the instruction; no partial write may occur after reset asserts.
- Cycle count with zero wait states: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4. Each `MemReady`=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- In FETCH with `MemReady`=0: IRWrite=0 and PCWrite=0. The select outputs stay stable.

## Test plan
- Reset with `MemReady`=1 and op=0110011, funct3 000, funct7b5 1:
  - During reset, all write enables are 0 and `State`=0.
  - After release, the state sequence is 0,1,6,8,0.
  - In EXECUTER, ALUControl=001.
  - In ALUWB, RegWrite=1.
  - `Retire` pulses once.
- lw with `MemReady` low for 2 cycles in MEMREAD:
  - The state sequence is 0,1,2,3,3,3,4,0.
  - AdrSrc=1 in every MEMREAD cycle.
  - In MEMWB, ResultSrc=01.
- sw with `MemReady`=0 for 1 cycle: MemWrite=1 for 2 consecutive cycles, then the state returns to FETCH.
- beq:
  - With `Zero`=1, PCWrite=1 in BEQ.
  - With `Zero`=0, PCWrite=0 in BEQ.
  - In both cases ImmSrc=10 and the FSM takes 3 cycles.
- jal: the state sequence is 0,1,10,8. In JAL, PCWrite=1, ImmSrc=11, ALUSrcA=01 and ALUSrcB=10.
- Illegal op 1111111:
  - The FSM enters TRAP, `Illegal`=1, and no enable asserts for 20 cycles.
  - Asserting `reset` low mid-stream returns the FSM to FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_if
// Brief    : Decode-field inputs and datapath control outputs of the controller
// Revision : 1.0
// ============================================================================
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       Retire;
  logic       Illegal;
  logic [3:0] State;

  modport slave (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Retire, Illegal, State
  );

  modport master (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Retire, Illegal, State
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore FSM sequencing a shared-memory, shared-ALU RV32I datapath
// Revision : 1.0
// ============================================================================
module multicycle_controller (
  input  wire logic               clk,
  input  wire logic               reset,
  multicycle_controller_if.slave  bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_alu_op;
  logic [2:0] w_alu_ctrl;
  logic [1:0] w_imm_src;
  logic       w_retire;
  logic       w_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          7'b0000011,
          7'b0100011: w_next = S_MEMADR;
          7'b0110011: w_next = S_EXECUTER;
          7'b0010011: w_next = S_EXECUTEI;
          7'b1100011: w_next = S_BEQ;
          7'b1101111: w_next = S_JAL;
          default:    w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = bus.MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      w_next = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BEQ:      w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_op     = ALUOP_ADD;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.MemReady;
        w_pc_update  = bus.MemReady;
      end
      S_DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
      end
      S_MEMREAD: w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = bus.MemReady;
      end
      S_EXECUTER: begin
        w_src_a  = 2'b10;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        w_src_a  = 2'b10;
        w_src_b  = 2'b01;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BEQ: begin
        w_src_a  = 2'b10;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_retire = 1'b1;
      end
      S_JAL: begin
        w_src_a     = 2'b01;
        w_src_b     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Only R-type (op[5]=1) can request sub through funct7; addi never does.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (w_alu_op)
      ALUOP_SUB: w_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (bus.funct3)
          3'b000:  w_alu_ctrl = (bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_ctrl = ALU_SLT;
          3'b110:  w_alu_ctrl = ALU_OR;
          3'b111:  w_alu_ctrl = ALU_AND;
          default: w_alu_ctrl = ALU_ADD;
        endcase
      end
      default: w_alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    case (bus.op)
      7'b0100011: w_imm_src = 2'b01;
      7'b1100011: w_imm_src = 2'b10;
      7'b1101111: w_imm_src = 2'b11;
      default:    w_imm_src = 2'b00;
    endcase
  end

  // Gate strobes with the raw reset so nothing writes while it is held low.
  assign bus.PCWrite    = reset & (w_pc_update | (w_branch & bus.Zero));
  assign bus.IRWrite    = reset & w_ir_write;
  assign bus.RegWrite   = reset & w_reg_write;
  assign bus.MemWrite   = reset & w_mem_write;
  assign bus.Retire     = reset & w_retire;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_src_a;
  assign bus.ALUSrcB    = w_src_b;
  assign bus.ALUControl = w_alu_ctrl;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.Illegal    = w_illegal;
  assign bus.State      = r_state;

endmodule
`default_nettype wire
